// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: IF/ID/EX/MEM/WB control FSM for the RV32 multi-cycle datapath.
// Define MEMSEQ_TIMEOUT_EN to add a memory-handshake watchdog that traps on a stalled request.
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned RETIRE_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          opcode,
   input  logic                branch_taken,
   input  logic                halt,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                ir_we,
   output logic                alu_en,
   output logic                rf_we,
   output logic                pc_we,
   output logic                pc_sel,
   output logic [2:0]          state,
   output logic                illegal_op,
   output logic                mem_timeout,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_LOAD, C_IMM, C_STORE, C_BRANCH, C_JAL, C_LUI, C_AUIPC
   } cls_t;

   state_t st;
   cls_t   cls;
   logic   expired;
   logic   br_ex;
   logic   st_done;

`ifdef MEMSEQ_TIMEOUT_EN
   localparam int unsigned CLOG = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CW   = (CLOG > 8) ? CLOG : 8;

   logic [CW-1:0] wait_cnt;
   logic          waiting;

   assign waiting = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
   assign expired = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES));

   // counter sits at zero while idle, so it restarts whenever a request rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (expired)
            mem_timeout <= 1'b1;
         if (!imem_req && !dmem_req)
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + CW'(1);
      end
   end
`else
   assign expired     = 1'b0;
   assign mem_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= S_IF;
         cls        <= C_R;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         illegal_op <= 1'b0;
         retired    <= '0;
      end else begin
         unique case (st)
            S_IF: begin
               if (!imem_req) begin
                  if (!halt)
                     imem_req <= 1'b1;
               end else if (imem_ready) begin
                  imem_req <= 1'b0;
                  st       <= S_ID;
               end else if (expired) begin
                  imem_req   <= 1'b0;
                  illegal_op <= 1'b1;
                  st         <= S_TRAP;
               end
            end
            S_ID: begin
               st <= S_EX;
               case (opcode)
                  7'b0110011: cls <= C_R;
                  7'b0000011: cls <= C_LOAD;
                  7'b0010011: cls <= C_IMM;
                  7'b0100011: cls <= C_STORE;
                  7'b1100011: cls <= C_BRANCH;
                  7'b1101111: cls <= C_JAL;
                  7'b0110111: cls <= C_LUI;
                  7'b0010111: cls <= C_AUIPC;
                  default: begin
                     illegal_op <= 1'b1;
                     st         <= S_TRAP;
                  end
               endcase
            end
            S_EX: begin
               if (cls == C_LOAD || cls == C_STORE) begin
                  st <= S_MEM;
               end else if (cls == C_BRANCH) begin
                  st      <= S_IF;
                  retired <= retired + RETIRE_W'(1);
               end else begin
                  st <= S_WB;
               end
            end
            // first MEM cycle only raises the request, mirroring IF
            S_MEM: begin
               if (!dmem_req) begin
                  dmem_req <= 1'b1;
               end else if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  if (cls == C_STORE) begin
                     st      <= S_IF;
                     retired <= retired + RETIRE_W'(1);
                  end else begin
                     st <= S_WB;
                  end
               end else if (expired) begin
                  dmem_req   <= 1'b0;
                  illegal_op <= 1'b1;
                  st         <= S_TRAP;
               end
            end
            S_WB: begin
               st      <= S_IF;
               retired <= retired + RETIRE_W'(1);
            end
            S_TRAP: begin
               illegal_op <= 1'b1;
            end
            default: begin
               illegal_op <= 1'b1;
               st         <= S_TRAP;
            end
         endcase
      end
   end

   assign br_ex   = (st == S_EX) && (cls == C_BRANCH);
   assign st_done = (st == S_MEM) && (cls == C_STORE) && dmem_req && dmem_ready;

   assign state   = st;
   assign ir_we   = (st == S_IF) && imem_req && imem_ready;
   assign alu_en  = (st == S_EX);
   assign rf_we   = (st == S_WB);
   assign dmem_we = dmem_req && (cls == C_STORE);
   assign pc_we   = br_ex || st_done || (st == S_WB);
   assign pc_sel  = (br_ex && branch_taken) || ((st == S_WB) && (cls == C_JAL));

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32 datapath; sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Takes the 7-bit opcode from the instruction register and issues per-cycle enables: PC write, IR write, ALU enable and register-file write.
- Runs request/ready handshakes to instruction memory and data memory.
- Sits between the instruction/data memory ports and the existing combinational opcode decoder. That decoder still supplies datapath muxing; this block supplies timing only.

Parameters:
- TIMEOUT_CYCLES, 255, max wait cycles on a memory handshake before trap (used only with the optional feature).
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- opcode  input  7  instr[6:0], valid from ID onward (IR output).
- branch_taken  input  1  comparator result, sampled in EX.
- halt  input  1  debug hold; sampled only in IF before a request is issued.
- imem_ready  input  1  instruction fetch complete.
- dmem_ready  input  1  data access complete.
- imem_req  output  1  instruction fetch request.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data write (valid with dmem_req).
- ir_we  output  1  latch fetched instruction.
- alu_en  output  1  ALU operate strobe.
- rf_we  output  1  register-file write strobe.
- pc_we  output  1  PC update strobe.
- pc_sel  output  1  0 = PC+4, 1 = branch/jal target.
- state  output  3  current state code.
- illegal_op  output  1  sticky trap flag.
- mem_timeout  output  1  sticky timeout flag; tied 0 without the macro.
- retired  output  RETIRE_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0, async):
  - state = IF (0).
  - imem_req, dmem_req, illegal_op, mem_timeout = 0; retired = 0; latched class = R.
  - All strobes are 0 while in reset.
- State codes: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP next cycle.
- imem_req and dmem_req are registered. All other strobes are decoded from registered state plus latched class. Each strobe is a single-cycle pulse except as noted.
- IF:
  - If imem_req=0 and halt=0: set imem_req next cycle.
  - Once imem_req=1 it holds (no retraction, halt ignored) until imem_ready=1.
  - On that edge: clear imem_req, pulse ir_we in the same cycle, go to ID.
  - Minimum IF time is 2 cycles.
- ID:
  - Classify opcode: 0110011 R, 0000011 LOAD, 0010011 IMM, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, 0010111 AUIPC.
  - Latch the class.
  - Any other opcode: go to TRAP. Otherwise go to EX.
- EX:
  - alu_en=1 for one cycle.
  - LOAD or STORE: go to MEM and set dmem_req next cycle (dmem_we=1 for STORE).
  - BRANCH: pc_we=1, pc_sel=branch_taken, retire, go to IF.
  - All other classes: go to WB.
- MEM:
  - dmem_req is held until dmem_ready=1, then cleared.
  - LOAD: go to WB.
  - STORE: pc_we=1, pc_sel=0 in the ready cycle, retire, go to IF.
- WB:
  - rf_we=1 (R, IMM, LOAD, JAL, LUI, AUIPC).
  - pc_we=1; pc_sel=1 for JAL, else 0.
  - Retire, go to IF.
- TRAP:
  - Absorbing state. illegal_op=1, all strobes 0, requests 0.
  - Exit only via reset.
- Retire: retired increments by 1 on the retiring edge and wraps modulo 2^RETIRE_W.
- Ready asserted while the corresponding req=0: ignored.
- Reset mid-handshake: request drops immediately. A late ready after reset release is ignored because req=0.
- Latency (zero-wait memories, from IF entry to next IF): R/IMM/LUI/AUIPC/JAL = 5 cycles, BRANCH = 4, LOAD = 7, STORE = 6.

Optional Feature:
- Macro: MEMSEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears when any request rises and increments each cycle the request is held without ready.
  - When the counter reaches TIMEOUT_CYCLES with ready still 0: drop the request, set mem_timeout=1 (sticky), go to TRAP.
  - Ready in the same cycle as the limit wins (no timeout).
- Undefined: no counter logic; mem_timeout tied 0; requests wait indefinitely.

Test Plan:
- Reset release, opcode=0110011, imem_ready=1 in the first req cycle -> state sequence 0,0,1,2,4,0; ir_we in cycle 1; alu_en in cycle 3; rf_we and pc_we (pc_sel=0) in cycle 4; retired=1.
- LOAD 0000011, dmem_ready 3 cycles after dmem_req rises -> dmem_req high exactly 4 cycles, dmem_we=0, then WB with rf_we=1; total 10 cycles.
- STORE 0100011 -> dmem_we=1 with dmem_req; rf_we never asserted; pc_we in the ready cycle; retired+1.
- BRANCH with branch_taken=1, then with 0 -> pc_we in EX with pc_sel=1 then 0; 4-cycle loop; no rf_we.
- Opcode 0000000 -> TRAP after ID, illegal_op=1 sticky; imem_ready pulses ignored; rst_n low clears it.
- halt=1 at IF entry for 5 cycles -> imem_req stays 0; with MEMSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no imem_ready -> mem_timeout=1, state=5.
